// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter slice:
// default geometry, FSM state encoding and a constant log2 helper.
package regfile_pkg;

  localparam int WIDTH_DEF     = 32;
  localparam int WORD_LINE_DEF = 3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Index width for n items; never below 1 so a 1-bit index always exists.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side handshake bundle: packed requests, addresses, data and the
// one-hot grant returned by the arbiter.
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int WORD_LINE = WORD_LINE_DEF
);

  logic [NREQ-1:0]           req;
  logic [NREQ*WORD_LINE-1:0] req_addr;
  logic [NREQ*WIDTH-1:0]     req_data;
  logic [NREQ-1:0]           gnt;

  modport master (output req, req_addr, req_data, input gnt);
  modport slave  (input req, req_addr, req_data, output gnt);

endinterface

// File: rtl/regfile_write_arbiter_rr.sv
// Combinational round-robin arbiter: searches upward from last+1 (mod NREQ)
// and returns a one-hot grant plus the encoded winner index.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = clog2(NREQ)
) (
  input  logic             en_i,
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  // NOTE: every output gets a default before the search loop so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] ci;
    logic             found;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    found = 1'b0;
    cand  = 0;
    ci    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_i) + k) % NREQ;
      ci   = IDX_W'(cand);
      if (en_i && !found && req_i[ci]) begin
        gnt_o[ci] = 1'b1;
        idx_o     = ci;
        vld_o     = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file write port among NREQ requesters,
// with a zero-fill of every entry after reset or soft clear.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int WORD_LINE = WORD_LINE_DEF,
  parameter int NREQ      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  regfile_write_arbiter_if.slave bus,
  output logic                 busy,
  output logic                 we,
  output logic [WORD_LINE-1:0] wa,
  output logic [WIDTH-1:0]     wd
);

  localparam int                   IDX_W      = clog2(NREQ);
  localparam logic [WORD_LINE-1:0] LAST_ENTRY = '1;
  localparam logic [IDX_W-1:0]     LAST_REQ   = IDX_W'(NREQ - 1);

  state_e               state_q;
  logic [WORD_LINE-1:0] clr_ptr_q;
  logic [IDX_W-1:0]     last_q;
  logic                 we_q;
  logic [WORD_LINE-1:0] wa_q;
  logic [WIDTH-1:0]     wd_q;

  logic                 arb_en;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic [WORD_LINE-1:0] win_addr;
  logic [WIDTH-1:0]     win_data;

  // clr masks the grant in the same cycle so no request is accepted on it.
  assign arb_en = (state_q == RUN) && !clr;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .en_i   (arb_en),
    .req_i  (bus.req),
    .last_i (last_q),
    .gnt_o  (bus.gnt),
    .idx_o  (gnt_idx),
    .vld_o  (gnt_vld)
  );

  assign win_addr = bus.req_addr[int'(gnt_idx)*WORD_LINE +: WORD_LINE];
  assign win_data = bus.req_data[int'(gnt_idx)*WIDTH +: WIDTH];

  // NOTE: state uses non-blocking assignments and an asynchronous reset, so
  // rst drops we immediately and discards any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= INIT;
      clr_ptr_q <= '0;
      last_q    <= LAST_REQ;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
    end else if (clr) begin
      state_q   <= INIT;
      clr_ptr_q <= '0;
      we_q      <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          we_q      <= 1'b1;
          wa_q      <= clr_ptr_q;
          wd_q      <= '0;
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_ENTRY) state_q <= RUN;
        end
        RUN: begin
          we_q <= gnt_vld;
          if (gnt_vld) begin
            wa_q   <= win_addr;
            wd_q   <= win_data;
            last_q <= gnt_idx;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign busy = (state_q == INIT);
  assign we   = we_q;
  assign wa   = wa_q;
  assign wd   = wd_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: a cycle-level behavioural model checked every negedge,
// plus directed scenarios pinned with hand-computed literal expectations.
module tb_regfile_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int WL    = 3;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             busy;
  logic             we;
  logic [WL-1:0]    wa;
  logic [WIDTH-1:0] wd;

  regfile_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .WORD_LINE(WL)) bus ();

  regfile_write_arbiter #(.WIDTH(WIDTH), .WORD_LINE(WL), .NREQ(NREQ)) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .bus  (bus),
    .busy (busy),
    .we   (we),
    .wa   (wa),
    .wd   (wd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_fill counts clear writes issued (DEPTH means accepting requests).
  int               m_fill;
  int               m_last;
  logic             m_we;
  logic [WL-1:0]    m_wa;
  logic [WIDTH-1:0] m_wd;
  logic [WIDTH-1:0] model_rf [DEPTH];
  logic [WIDTH-1:0] dut_rf   [DEPTH];
  logic [NREQ-1:0]  gnt_seen;
  logic [NREQ-1:0]  one_shot;

  function automatic logic [NREQ-1:0] model_gnt();
    logic [NREQ-1:0] g;
    g = '0;
    if (rst || clr || m_fill < DEPTH) return g;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (bus.req[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] eg;
    if (rst) begin
      m_fill = 0;
      m_last = NREQ - 1;
      m_we   = 1'b0;
      m_wa   = '0;
      m_wd   = '0;
      for (int e = 0; e < DEPTH; e++) begin
        dut_rf[e]   = 32'hDEAD_BEEF;
        model_rf[e] = 32'hDEAD_BEEF;
      end
    end
    eg = model_gnt();
    check("gnt",  32'(bus.gnt), 32'(eg));
    check("busy", 32'(busy),    32'(m_fill < DEPTH));
    check("we",   32'(we),      32'(m_we));
    check("wa",   32'(wa),      32'(m_wa));
    check("wd",   wd,           m_wd);
    gnt_seen = bus.gnt;
    if (we === 1'b1) dut_rf[wa] = wd;
    if (!rst) begin
      if (clr) begin
        m_fill = 0;
        m_we   = 1'b0;
      end else if (m_fill < DEPTH) begin
        m_we   = 1'b1;
        m_wa   = WL'(m_fill);
        m_wd   = '0;
        model_rf[m_fill] = '0;
        m_fill++;
      end else if (eg != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (eg[i]) begin
            m_we   = 1'b1;
            m_wa   = bus.req_addr[i*WL +: WL];
            m_wd   = bus.req_data[i*WIDTH +: WIDTH];
            m_last = i;
            model_rf[m_wa] = m_wd;
          end
        end
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // Advance one cycle; requesters in one_shot mode drop a granted request.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.req = bus.req & ~(one_shot & gnt_seen);
  endtask

  task automatic set_req(input int i, input logic [WL-1:0] a, input logic [WIDTH-1:0] d);
    bus.req_addr[i*WL +: WL]       = a;
    bus.req_data[i*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    rst          = 1'b1;
    clr          = 1'b0;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    one_shot     = '1;
    tick();
    tick();
    rst = 1'b0;

    // Zero-fill after reset release.
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check("fill_we",   32'(we),   32'd1);
      check("fill_wa",   32'(wa),   32'(i));
      check("fill_wd",   wd,        32'd0);
      check("fill_busy", 32'(busy), (i == DEPTH - 1) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    #1;
    for (int e = 0; e < DEPTH; e++) check("fill_rf", dut_rf[e], 32'd0);

    // Single requester.
    tick();
    set_req(2, 3'd5, 32'hA5A5_0001);
    bus.req = 4'b0100;
    #1;
    check("single_gnt", 32'(bus.gnt), 32'h4);
    tick();
    check("single_we", 32'(we), 32'd1);
    check("single_wa", 32'(wa), 32'd5);
    check("single_wd", wd,      32'hA5A5_0001);
    tick();
    check("single_rf", dut_rf[5], 32'hA5A5_0001);

    // Round-robin fairness from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (DEPTH) tick();
    for (int i = 0; i < NREQ; i++) set_req(i, WL'(i), 32'h300 + 32'(i));
    one_shot = '0;
    bus.req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_gnt", 32'(bus.gnt), 32'(1 << (k % NREQ)));
      tick();
      check("rr_we", 32'(we), 32'd1);
      check("rr_wa", 32'(wa), 32'(k % NREQ));
    end
    bus.req  = '0;
    one_shot = '1;

    // Same-address conflict: request order decides, last write wins.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 3'd3, 32'd10);
    set_req(1, 3'd3, 32'd30);
    bus.req = 4'b0011;
    #1;
    check("same_busy_gnt", 32'(bus.gnt), 32'd0);
    repeat (DEPTH) tick();
    #1;
    check("same_gnt0", 32'(bus.gnt), 32'h1);
    tick();
    check("same_wd0", wd, 32'd10);
    #1;
    check("same_gnt1", 32'(bus.gnt), 32'h2);
    tick();
    check("same_wa1", 32'(wa), 32'd3);
    check("same_wd1", wd,      32'd30);
    tick();
    check("same_rf", dut_rf[3], 32'd30);

    // Soft clear while a request is pending.
    set_req(1, 3'd6, 32'h0000_C1C1);
    bus.req = 4'b0010;
    clr     = 1'b1;
    #1;
    check("clr_gnt", 32'(bus.gnt), 32'd0);
    tick();
    clr = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_we",   32'(we),   32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("clr_fill_gnt", 32'(bus.gnt), 32'd0);
      tick();
      check("clr_fill_wa", 32'(wa), 32'(i));
    end
    check("clr_done_busy", 32'(busy), 32'd0);
    #1;
    check("clr_after_gnt", 32'(bus.gnt), 32'h2);
    tick();
    check("clr_after_wa", 32'(wa), 32'd6);
    check("clr_after_wd", wd,      32'h0000_C1C1);

    // Asynchronous reset while a write is in flight.
    one_shot = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, WL'(7 - i), 32'h600 + 32'(i));
    bus.req = 4'b1111;
    tick();
    tick();
    check("arst_pre_we", 32'(we), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_we",   32'(we),   32'd0);
    check("arst_busy", 32'(busy), 32'd1);
    tick();
    rst     = 1'b0;
    bus.req = '0;
    tick();
    check("arst_restart_we", 32'(we), 32'd1);
    check("arst_restart_wa", 32'(wa), 32'd0);
    repeat (DEPTH) tick();
    @(negedge clk);
    #1;
    for (int e = 0; e < DEPTH; e++) check("final_rf", dut_rf[e], model_rf[e]);
    check("final_rf0", dut_rf[0], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port (we/wa/wd) of the 32-bit x 8-entry register file among NREQ independent write requesters using round-robin arbitration. After reset, or on a soft-clear request, it first sequences a zero-fill of every register entry. Only then does it accept requests. Sits directly in front of the register-file write port; read ports are untouched.

Parameters:
WIDTH, 32, data width of one register (matches register file)
WORD_LINE, 3, address width; entry count = 2**WORD_LINE
NREQ, 4, number of write requesters (2..8)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  soft clear; 1-cycle pulse restarts zero-fill sequence
req  input  NREQ  per-requester write request, held until granted
req_addr  input  NREQ*WORD_LINE  packed write addresses, requester i at [i*WORD_LINE +: WORD_LINE]
req_data  input  NREQ*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, combinational; request accepted at the rising edge where req[i]&gnt[i]
busy  output  1  high while zero-fill in progress (state INIT)
we  output  1  registered write enable to register file
wa  output  WORD_LINE  registered write address
wd  output  WIDTH  registered write data

Behaviour:
- Reset (async, rst=1): state=INIT, clr_ptr=0, last=NREQ-1 (req0 highest priority first), we=0, wa=0, wd=0. gnt=0, busy=1 while in INIT.
- States:
  - INIT: gnt forced 0. Each edge registers we=1, wa=clr_ptr, wd=0, then increments clr_ptr. On the edge that registers clr_ptr==2**WORD_LINE-1: clr_ptr wraps to 0 and state->RUN.
  - RUN: each edge registers the winner's addr/data with we=1. If no request is present, we=0 is registered and wa/wd hold their previous values.
- Zero-fill timing: after rst release, edges 1..8 register wa=0..7 with we=1, and busy falls after edge 8. The register file completes the last clear one edge later.
- Arbitration:
  - Among asserted req bits, grant the first index searching upward from last+1 (mod NREQ).
  - At most one gnt bit set. gnt may be high only when the matching req is high and state==RUN.
  - On the accepting edge, last := granted index; last is unchanged when nothing is granted.
- Latency: accepted at edge k -> we/wa/wd valid in cycle k..k+1 -> register file written at edge k+1. Throughput: one write per cycle.
- Handshake: a requester must hold req/addr/data stable until it samples gnt high at an edge, then may deassert or present the next write. Repeated grants to a persistently asserted requester are legal only when no other requester is waiting.
- Same-address conflicts: requests are serialized in grant order; the last write wins. No merging or bypass.
- clr:
  - In RUN: next edge state->INIT, clr_ptr=0. The gnt in that cycle is suppressed to 0, so no request is accepted. Any write already registered still completes.
  - In INIT: restarts with clr_ptr=0.
  - clr has priority over request acceptance in the same cycle.
- rst mid-operation: immediately forces we=0, discarding any in-flight write, and restarts zero-fill.
- Width rules: clr_ptr is WORD_LINE bits with natural wrap. last and the search index are ceil(log2(NREQ)) bits with explicit mod-NREQ wrap.

Decomposition:
- Shared package regfile_pkg: WIDTH/WORD_LINE defaults, state encoding (INIT=1'b0, RUN=1'b1), clog2 helper.
- Sub-module rr_arbiter (NREQ): combinational one-hot grant from req/last plus granted-index encode. Reusable by future read-port sharing.
- The top level holds the FSM, clr_ptr, last register, output registers and data mux.

Test Plan:
1. Zero-fill: rst released with no req -> we=1, wa=0..7, wd=0 on 8 consecutive cycles; busy=0 after edge 8. Read ports ra0/ra1 then return 0 for all entries.
2. Single requester: req[2]=1, addr=5, data=32'hA5A5_0001 -> gnt=4'b0100 same cycle; next cycle we=1, wa=5, wd=A5A5_0001; rd0 at ra0=5 returns that value afterwards.
3. Round-robin fairness: req=4'b1111 held, distinct addrs 0..3 -> grant order 0,1,2,3,0 on consecutive cycles, we=1 every cycle.
4. Same address: req0 (addr 3, data 10) and req1 (addr 3, data 30) together from reset -> req0 written first, then req1; entry 3 reads 30.
5. clr during RUN: req[1] asserted, pulse clr -> gnt=0 that cycle, busy=1 next cycle, 8 clear writes follow; req[1] is granted only after busy falls.
6. Async reset mid-stream: assert rst between edges while we=1 -> we drops to 0 without waiting for a clock edge; sequence restarts at wa=0 after release.
